dmem_scrub_ctrl: RTL and testbench
==================================

Name: dmem_scrub_ctrl

Overview:
- Background ECC scrubber and port arbiter for the Hamming-protected data memory of the pipelined RISC-V core.
- Walks the data memory one word at a time on a programmable interval, using idle cycles only; the CPU always has priority.
- On a single-bit error it writes the corrected word back; on a double-bit error it logs the address and does not write.
- Sits beside Pipeline_top's memory stage and drives the dmem address/write mux select.

Parameters:
DATA_W, 32, data word width (corrected data from the Hamming decoder)
ADDR_W, 6, word address width
DEPTH, 64, number of words scrubbed per pass (addresses 0..DEPTH-1)
CNT_W, 16, width of error counters and interval

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  scrubbing enabled
interval  input  CNT_W  idle cycles between scrub reads (0 treated as 1)
clr_counts  input  1  synchronous clear of counters and DED log
cpu_req  input  1  CPU memory stage uses dmem this cycle (MemRead or MemWrite)
cpu_we  input  1  CPU access is a store
cpu_addr  input  ADDR_W  CPU word address
mem_rdata  input  DATA_W  corrected read data from dmem decoder (combinational read)
mem_err  input  1  decoder error flag (dmem_error)
mem_err_type  input  1  0 = single-bit corrected, 1 = double-bit (error_type_dmem)
scrub_active  output  1  dmem port driven by scrubber this cycle
scrub_addr  output  ADDR_W  scrub pointer / dmem address when active
scrub_we  output  1  scrub writeback strobe (only with scrub_active)
scrub_wdata  output  DATA_W  corrected word to write back
sec_count  output  CNT_W  single-bit corrections written, saturating
ded_count  output  CNT_W  double-bit detections, saturating
ded_addr  output  ADDR_W  address of most recent double-bit error
ded_flag  output  1  sticky double-bit error indicator
pass_done  output  1  one-cycle pulse when pointer wraps DEPTH-1 -> 0

Behaviour:
- Reset: state IDLE; all outputs 0; pointer 0; interval counter 0.
- Arbitration: scrub_active = 1 only in READ or WB and only when cpu_req = 0. When cpu_req = 1 the scrubber stalls in its current state with scrub_active = scrub_we = 0.
- IDLE: when enable = 1, load the interval counter with max(interval, 1) and go to WAIT.
- WAIT: decrement the counter each cycle; at 1, go to READ.
- READ (granted cycle): sample mem_rdata, mem_err, mem_err_type at scrub_addr in the same cycle.
  - No error: advance pointer, go to WAIT.
  - Single-bit error: latch mem_rdata into scrub_wdata, go to WB; pointer holds.
  - Double-bit error: ded_count++, ded_addr <= scrub_addr, ded_flag <= 1, advance pointer, go to WAIT. No writeback.
- WB (granted cycle): scrub_we = 1 for exactly one cycle, sec_count++, advance pointer, go to WAIT.
- WB hazard: if a CPU store to scrub_addr (cpu_req & cpu_we & cpu_addr == scrub_addr) occurs while WB is pending, drop the writeback. sec_count is not incremented; advance pointer, go to WAIT. The CPU data is newer.
- Pointer wrap: advancing from DEPTH-1 sets the pointer to 0 and pulses pass_done for one cycle.
- enable = 0:
  - In WAIT or READ: go to IDLE next cycle.
  - In WB: complete (or drop) the writeback first, then go to IDLE.
  - The pointer is retained; the next pass resumes at the same address.
- Counters saturate at all-ones.
- clr_counts clears sec_count, ded_count, ded_addr and ded_flag. If an increment occurs in the same cycle, the counter becomes 1; for a DED in the same cycle, ded_flag = 1 and ded_addr is the new address.
- interval changes take effect at the next WAIT load.
- Asynchronous reset mid-operation aborts any pending writeback. No partial write is issued.

Test Plan:
- Clean memory, interval=4, DEPTH=64, cpu_req=0 -> one scrub read every 5 cycles; pass_done pulses after address 63; counters stay 0.
- Flip bit 6 of word 1 (via hierarchical access) -> READ at addr 1 flags single; next granted cycle scrub_we=1, scrub_wdata = original word; sec_count=1; re-read of word 1 shows mem_err=0.
- Flip bits 5 and 6 of word 1 -> ded_count=1, ded_addr=1, ded_flag=1, no scrub_we; clr_counts clears all four.
- Hold cpu_req=1 for 10 cycles while READ/WB is pending -> scrub_active stays 0 throughout; the operation completes on the first cycle with cpu_req=0.
- Single error pending at addr 3, CPU stores to addr 3 before the grant -> no scrub_we, sec_count unchanged, pointer advances to 4.
- Deassert enable during WB, then assert rst mid-WAIT -> the writeback completes, then IDLE; after reset all outputs are 0 and the pointer is 0.

Source files
------------

// File: rtl/dmem_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_scrub_ctrl
// Description : Background ECC scrubber and dmem port arbiter. Reads one word
//               per programmable interval on idle cycles, writes back single-
//               bit corrections and logs double-bit detections.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_scrub_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  interval,
    input  logic              clr_counts,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    input  logic              mem_err_type,
    output logic              scrub_active,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic              scrub_we,
    output logic [DATA_W-1:0] scrub_wdata,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              ded_flag,
    output logic              pass_done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_READ = 2'd2;
    localparam logic [1:0] c_WB   = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_sec_cnt;
    logic [CNT_W-1:0]  r_ded_cnt;
    logic [ADDR_W-1:0] r_ded_addr;
    logic              r_ded_flag;
    logic              r_pass_done;

    logic              w_grant;
    logic              w_hazard;
    logic              w_single;
    logic [CNT_W-1:0]  w_interval_eff;

    logic              w_active;
    logic              w_we;
    logic              w_load_cnt;
    logic              w_dec_cnt;
    logic              w_advance;
    logic              w_latch_wdata;
    logic              w_sec_inc;
    logic              w_ded_inc;

    assign w_grant        = ~cpu_req;
    // A CPU store to the word awaiting writeback makes the corrected copy stale.
    assign w_hazard       = cpu_req & cpu_we & (cpu_addr == r_ptr);
    assign w_single       = mem_err & ~mem_err_type;
    assign w_interval_eff = (interval == '0) ? c_CNT_ONE : interval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable) begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (!enable) begin
                    w_next_state = c_IDLE;
                end else if (r_wait_cnt <= c_CNT_ONE) begin
                    w_next_state = c_READ;
                end
            end
            c_READ: begin
                if (!enable) begin
                    w_next_state = c_IDLE;
                end else if (w_grant) begin
                    w_next_state = w_single ? c_WB : c_WAIT;
                end
            end
            c_WB: begin
                if (w_grant || w_hazard) begin
                    w_next_state = enable ? c_WAIT : c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_active      = 1'b0;
        w_we          = 1'b0;
        w_load_cnt    = 1'b0;
        w_dec_cnt     = 1'b0;
        w_advance     = 1'b0;
        w_latch_wdata = 1'b0;
        w_sec_inc     = 1'b0;
        w_ded_inc     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_load_cnt = enable;
            end
            c_WAIT: begin
                w_dec_cnt = enable & (r_wait_cnt > c_CNT_ONE);
            end
            c_READ: begin
                w_active = w_grant;
                if (enable && w_grant) begin
                    if (w_single) begin
                        w_latch_wdata = 1'b1;
                    end else begin
                        w_advance  = 1'b1;
                        w_load_cnt = 1'b1;
                        w_ded_inc  = mem_err;
                    end
                end
            end
            c_WB: begin
                w_active = w_grant;
                w_we     = w_grant;
                if (w_grant || w_hazard) begin
                    w_advance  = 1'b1;
                    w_load_cnt = 1'b1;
                    w_sec_inc  = w_grant;
                end
            end
            default: begin
                w_active = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_wait_cnt  <= '0;
            r_wdata     <= '0;
            r_pass_done <= 1'b0;
        end else begin
            r_pass_done <= w_advance & (r_ptr == c_LAST_ADDR);
            if (w_advance) begin
                r_ptr <= (r_ptr == c_LAST_ADDR) ? '0 : r_ptr + 1'b1;
            end
            if (w_load_cnt) begin
                r_wait_cnt <= w_interval_eff;
            end else if (w_dec_cnt) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_latch_wdata) begin
                r_wdata <= mem_rdata;
            end
        end
    end

    // A clear coinciding with an event leaves that event recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_cnt  <= '0;
            r_ded_cnt  <= '0;
            r_ded_addr <= '0;
            r_ded_flag <= 1'b0;
        end else begin
            if (clr_counts) begin
                r_sec_cnt <= w_sec_inc ? c_CNT_ONE : '0;
            end else if (w_sec_inc && (r_sec_cnt != c_CNT_MAX)) begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
            end
            if (clr_counts) begin
                r_ded_cnt <= w_ded_inc ? c_CNT_ONE : '0;
            end else if (w_ded_inc && (r_ded_cnt != c_CNT_MAX)) begin
                r_ded_cnt <= r_ded_cnt + 1'b1;
            end
            if (w_ded_inc) begin
                r_ded_addr <= r_ptr;
                r_ded_flag <= 1'b1;
            end else if (clr_counts) begin
                r_ded_addr <= '0;
                r_ded_flag <= 1'b0;
            end
        end
    end

    assign scrub_active = w_active;
    assign scrub_we     = w_we;
    assign scrub_addr   = r_ptr;
    assign scrub_wdata  = r_wdata;
    assign sec_count    = r_sec_cnt;
    assign ded_count    = r_ded_cnt;
    assign ded_addr     = r_ded_addr;
    assign ded_flag     = r_ded_flag;
    assign pass_done    = r_pass_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_scrub_ctrl
// Description : Directed self-checking bench for dmem_scrub_ctrl with a small
//               behavioural dmem/decoder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_scrub_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] interval;
    logic          clr_counts;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;
    logic          mem_err_type;
    logic          scrub_active;
    logic [AW-1:0] scrub_addr;
    logic          scrub_we;
    logic [DW-1:0] scrub_wdata;
    logic [CW-1:0] sec_count;
    logic [CW-1:0] ded_count;
    logic [AW-1:0] ded_addr;
    logic          ded_flag;
    logic          pass_done;

    logic [DW-1:0] tb_mem  [0:63];
    logic          tb_err  [0:63];
    logic          tb_type [0:63];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Decoder model: returns the corrected word plus the error flags of the word.
    assign mem_rdata    = tb_mem[scrub_addr];
    assign mem_err      = tb_err[scrub_addr];
    assign mem_err_type = tb_type[scrub_addr];

    dmem_scrub_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .interval(interval),
        .clr_counts(clr_counts), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .mem_err_type(mem_err_type), .scrub_active(scrub_active),
        .scrub_addr(scrub_addr), .scrub_we(scrub_we), .scrub_wdata(scrub_wdata),
        .sec_count(sec_count), .ded_count(ded_count), .ded_addr(ded_addr),
        .ded_flag(ded_flag), .pass_done(pass_done)
    );

    function automatic logic [DW-1:0] word_of(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory writes are applied just after the edge to avoid racing the DUT.
    task automatic nc();
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          cs;
        logic [AW-1:0] ca;
        #1;
        w  = scrub_we;
        a  = scrub_addr;
        d  = scrub_wdata;
        cs = cpu_req & cpu_we;
        ca = cpu_addr;
        @(posedge clk);
        #1;
        if (w) begin
            tb_mem[a] = d;
            tb_err[a] = 1'b0;
        end
        if (cs) tb_err[ca] = 1'b0;
    endtask

    task automatic wait_read(input logic [AW-1:0] a, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (scrub_active && !scrub_we && scrub_addr == a) found = 1'b1;
            else nc();
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; interval = 16'd4; clr_counts = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = word_of(i); tb_err[i] = 1'b0; tb_type[i] = 1'b0;
        end
        nc(); nc();
        check("rst_active", 64'(scrub_active), 64'd0);
        check("rst_we",     64'(scrub_we),     64'd0);
        check("rst_addr",   64'(scrub_addr),   64'd0);
        check("rst_wdata",  64'(scrub_wdata),  64'd0);
        check("rst_counts", 64'({sec_count, ded_count}), 64'd0);
        check("rst_ded",    64'({ded_addr, ded_flag, pass_done}), 64'd0);

        // Clean pass, interval 4: one read every 5 cycles
        rst = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            nc(); check("gap_first_read", 64'(scrub_active), 64'(i == 5));
        end
        check("first_read_addr", 64'(scrub_addr), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            nc(); check("gap_second_read", 64'(scrub_active), 64'(i == 5));
        end
        check("second_read_addr", 64'(scrub_addr), 64'd1);
        n = 0;
        for (int j = 1; j <= 400; j++) begin
            nc();
            if (pass_done) begin n = j; break; end
        end
        check("pass_done_latency", 64'(n), 64'd311);
        check("wrap_addr", 64'(scrub_addr), 64'd0);
        nc();
        check("pass_done_one_cycle", 64'(pass_done), 64'd0);
        check("clean_counts", 64'({sec_count, ded_count, 15'd0, ded_flag}), 64'd0);

        // Single-bit error at word 1
        tb_err[1] = 1'b1; tb_type[1] = 1'b0;
        wait_read(6'd1, 40, "sec_read_seen");
        nc();
        check("sec_we",    64'(scrub_we),    64'd1);
        check("sec_wdata", 64'(scrub_wdata), 64'(word_of(1)));
        nc();
        check("sec_count", 64'(sec_count),  64'd1);
        check("sec_addr",  64'(scrub_addr), 64'd2);
        check("sec_reread_clean", 64'(tb_err[1]), 64'd0);

        // Double-bit error at word 1, then clear
        tb_err[1] = 1'b1; tb_type[1] = 1'b1;
        wait_read(6'd1, 400, "ded_read_seen");
        check("ded_no_we_read", 64'(scrub_we), 64'd0);
        nc();
        check("ded_count", 64'(ded_count),  64'd1);
        check("ded_addr",  64'(ded_addr),   64'd1);
        check("ded_flag",  64'(ded_flag),   64'd1);
        check("ded_no_we", 64'(scrub_we),   64'd0);
        check("ded_ptr",   64'(scrub_addr), 64'd2);
        tb_err[1] = 1'b0; tb_type[1] = 1'b0;
        clr_counts = 1'b1;
        nc();
        clr_counts = 1'b0;
        check("clr_all", 64'({sec_count, ded_count, ded_addr, ded_flag}), 64'd0);

        // CPU holds the port through a pending READ and WB
        tb_err[5] = 1'b1;
        wait_read(6'd5, 60, "stall_read_seen");
        cpu_req = 1'b1; cpu_addr = 6'd20;
        for (int i = 0; i < 10; i++) begin
            nc(); check("stall_read_active", 64'(scrub_active), 64'd0);
        end
        cpu_req = 1'b0; #1;
        check("stall_read_resume", 64'({scrub_active, scrub_we, scrub_addr}), 64'({1'b1, 1'b0, 6'd5}));
        nc();
        check("stall_wb_we", 64'(scrub_we), 64'd1);
        cpu_req = 1'b1; #1;
        check("stall_wb_blocked", 64'(scrub_we), 64'd0);
        for (int i = 0; i < 10; i++) begin
            nc(); check("stall_wb_active", 64'({scrub_active, scrub_we}), 64'd0);
        end
        cpu_req = 1'b0; #1;
        check("stall_wb_resume", 64'(scrub_we), 64'd1);
        check("stall_wb_wdata", 64'(scrub_wdata), 64'(word_of(5)));
        nc();
        check("stall_sec_count", 64'(sec_count),  64'd1);
        check("stall_ptr",       64'(scrub_addr), 64'd6);

        // CPU store to the pending writeback address drops the writeback
        tb_err[3] = 1'b1;
        wait_read(6'd3, 400, "hazard_read_seen");
        nc();
        check("hazard_wb_pending", 64'(scrub_we), 64'd1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd3; #1;
        check("hazard_we_blocked", 64'(scrub_we), 64'd0);
        nc();
        cpu_req = 1'b0; cpu_we = 1'b0; #1;
        check("hazard_ptr",   64'(scrub_addr), 64'd4);
        check("hazard_count", 64'(sec_count),  64'd1);
        check("hazard_idle",  64'({scrub_active, scrub_we}), 64'd0);

        // Disable during WB completes the writeback, then reset mid-WAIT
        tb_err[6] = 1'b1;
        wait_read(6'd6, 60, "dis_read_seen");
        nc();
        enable = 1'b0; #1;
        check("dis_wb_we", 64'(scrub_we), 64'd1);
        nc();
        check("dis_sec_count", 64'(sec_count),  64'd2);
        check("dis_ptr",       64'(scrub_addr), 64'd7);
        nc(); nc();
        check("dis_idle", 64'({scrub_active, scrub_addr}), 64'({1'b0, 6'd7}));
        enable = 1'b1;
        nc(); nc(); nc();
        rst = 1'b1; #1;
        check("arst_outputs", 64'({scrub_active, scrub_we, scrub_addr, pass_done, ded_flag}), 64'd0);
        check("arst_counts",  64'({sec_count, ded_count}), 64'd0);
        check("arst_wdata",   64'(scrub_wdata), 64'd0);
        nc();
        rst = 1'b0;

        // Interval 0 behaves as 1: one read every 2 cycles
        interval = 16'd0;
        for (int i = 1; i <= 2; i++) begin
            nc(); check("iv0_gap_first", 64'(scrub_active), 64'(i == 2));
        end
        check("iv0_addr0", 64'(scrub_addr), 64'd0);
        for (int i = 1; i <= 2; i++) begin
            nc(); check("iv0_gap_second", 64'(scrub_active), 64'(i == 2));
        end
        check("iv0_addr1", 64'(scrub_addr), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
